// File: rtl/palette_access_ctrl.sv
// rtl/palette_access_ctrl.sv - palette RAM slot arbiter: video reads, host read FSM, host write FIFO
// Optional: PALETTE_BLANK_ONLY_WR_EN restricts FIFO drain to video blanking.
module palette_access_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              video_rd_req,
    input  logic [ADDR_W-1:0] video_rd_addr,
    input  logic              video_blank,
    output logic [DATA_W-1:0] video_rd_data,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic              host_rd_busy,
    output logic              host_rd_valid,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              wr_overflow,
    input  logic              ovf_clear,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr_en,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_ISSUE, ST_CAPT} rd_state_t;

    rd_state_t         rd_state;
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              video_p1;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              rd_issue;
    logic              drain_ok;

`ifdef PALETTE_BLANK_ONLY_WR_EN
    assign drain_ok = video_blank;
`else
    logic unused_blank;
    assign unused_blank = video_blank;
    assign drain_ok     = 1'b1;
`endif

    assign fifo_empty    = (count == '0);
    assign host_wr_ready = (count != FULL_CNT);
    assign push          = host_wr_valid & host_wr_ready;
    // A DRAIN cycle that already sees an empty FIFO issues the read itself.
    assign rd_issue = !video_rd_req &&
                      ((rd_state == ST_ISSUE) || (rd_state == ST_DRAIN && fifo_empty));
    assign pop      = !video_rd_req && !rd_issue && !fifo_empty && drain_ok;

    always_comb begin
        ram_addr    = '0;
        ram_wr_en   = 1'b0;
        ram_wr_data = '0;
        if (video_rd_req) begin
            ram_addr = video_rd_addr;
        end else if (rd_issue) begin
            ram_addr = rd_addr_q;
        end else if (pop) begin
            ram_addr    = fifo_addr[rd_ptr];
            ram_wr_en   = 1'b1;
            ram_wr_data = fifo_data[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= host_wr_addr;
            fifo_data[wr_ptr] <= host_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            wr_overflow   <= 1'b0;
            video_p1      <= 1'b0;
            video_rd_data <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (host_wr_valid && !host_wr_ready) wr_overflow <= 1'b1;
            else if (ovf_clear)                  wr_overflow <= 1'b0;
            video_p1 <= video_rd_req;
            if (video_p1) video_rd_data <= ram_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state      <= ST_IDLE;
            rd_addr_q     <= '0;
            host_rd_busy  <= 1'b0;
            host_rd_valid <= 1'b0;
            host_rd_data  <= '0;
        end else begin
            host_rd_valid <= 1'b0;
            case (rd_state)
                ST_IDLE: begin
                    if (host_rd_req) begin
                        rd_addr_q    <= host_rd_addr;
                        host_rd_busy <= 1'b1;
                        rd_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) rd_state <= rd_issue ? ST_CAPT : ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (rd_issue) rd_state <= ST_CAPT;
                end
                ST_CAPT: begin
                    host_rd_data  <= ram_rd_data;
                    host_rd_valid <= 1'b1;
                    host_rd_busy  <= 1'b0;
                    rd_state      <= ST_IDLE;
                end
                default: rd_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_palette_access_ctrl.sv
// tb/tb_palette_access_ctrl.sv - directed and random checks of palette_access_ctrl against a transaction model
module tb_palette_access_ctrl;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        video_rd_req;
    logic [7:0]  video_rd_addr;
    logic        video_blank;
    logic [11:0] video_rd_data;
    logic        host_wr_valid;
    logic        host_wr_ready;
    logic [7:0]  host_wr_addr;
    logic [11:0] host_wr_data;
    logic        host_rd_req;
    logic [7:0]  host_rd_addr;
    logic        host_rd_busy;
    logic        host_rd_valid;
    logic [11:0] host_rd_data;
    logic        wr_overflow;
    logic        ovf_clear;
    logic [7:0]  ram_addr;
    logic        ram_wr_en;
    logic [11:0] ram_wr_data;
    logic [11:0] ram_rd_data;

    palette_access_ctrl #(.FIFO_DEPTH(DEPTH), .ADDR_W(8), .DATA_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .video_rd_req(video_rd_req), .video_rd_addr(video_rd_addr),
        .video_blank(video_blank), .video_rd_data(video_rd_data),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
        .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
        .host_rd_busy(host_rd_busy), .host_rd_valid(host_rd_valid),
        .host_rd_data(host_rd_data), .wr_overflow(wr_overflow),
        .ovf_clear(ovf_clear), .ram_addr(ram_addr), .ram_wr_en(ram_wr_en),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM with a preload port used during reset.
    logic        load_en;
    logic [7:0]  load_addr;
    logic [11:0] load_data;
    logic [11:0] mem [256];
    always @(posedge clk) begin
        if (load_en)        mem[load_addr] <= load_data;
        else if (ram_wr_en) mem[ram_addr]  <= ram_wr_data;
        ram_rd_data <= mem[ram_addr];
    end

    typedef struct { logic [7:0] a; logic [11:0] d; } wr_t;
    typedef struct { int due; logic [11:0] v; } sched_t;

    int          n_err = 0;
    int          n_checks = 0;
    int          cyc = 0;
    logic [11:0] shadow [256];
    wr_t         wq [$];
    sched_t      vq [$];
    sched_t      hq [$];
    logic [11:0] exp_vid = '0;
    logic [11:0] exp_hrd = '0;
    bit          ovf_m = 0;
    bit          rd_active = 0;
    bit          rd_drained = 0;
    bit          rd_issued = 0;
    int          rd_t = 0;
    int          rd_ic = 0;
    logic [7:0]  rd_a = '0;
    bit          obs_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        video_rd_req = 0; video_rd_addr = '0; video_blank = 1;
        host_wr_valid = 0; host_wr_addr = '0; host_wr_data = '0;
        host_rd_req = 0; host_rd_addr = '0; ovf_clear = 0;
    endtask

    // One clock: sample outputs mid-cycle, compare with the model, advance the model.
    task automatic step();
        bit     ready_e, busy_e, issue, pop, blank_ok, hvalid_e;
        sched_t s;
        wr_t    w;
        @(negedge clk);
        hvalid_e = 0;
        while (vq.size() > 0 && vq[0].due == cyc) begin
            s = vq.pop_front();
            exp_vid = s.v;
        end
        if (hq.size() > 0 && hq[0].due == cyc) begin
            s = hq.pop_front();
            exp_hrd = s.v;
            hvalid_e = 1;
        end
`ifdef PALETTE_BLANK_ONLY_WR_EN
        blank_ok = video_blank;
`else
        blank_ok = 1'b1;
`endif
        ready_e = wq.size() < DEPTH;
        busy_e  = rd_active && cyc > rd_t;
        issue   = 0;
        if (busy_e && !rd_issued) begin
            if (!rd_drained && wq.size() == 0) rd_drained = 1;
            if (rd_drained && !video_rd_req) begin
                issue = 1; rd_issued = 1; rd_ic = cyc;
            end
        end
        pop = !video_rd_req && !issue && wq.size() > 0 && blank_ok;

        chk("wr_ready", host_wr_ready, ready_e);
        chk("rd_busy", host_rd_busy, busy_e);
        chk("rd_valid", host_rd_valid, hvalid_e);
        chk("rd_data", host_rd_data, exp_hrd);
        chk("vid_data", video_rd_data, exp_vid);
        chk("overflow", wr_overflow, ovf_m);
        chk("ram_wr_en", ram_wr_en, pop);
        if (video_rd_req)  chk("ram_addr_vid", ram_addr, video_rd_addr);
        else if (issue)    chk("ram_addr_rd", ram_addr, rd_a);
        else if (pop) begin
            chk("ram_addr_wr", ram_addr, wq[0].a);
            chk("ram_wr_data", ram_wr_data, wq[0].d);
        end
        obs_valid = host_rd_valid;

        if (pop) begin
            w = wq.pop_front();
            shadow[w.a] = w.d;
        end
        if (video_rd_req) begin
            s.due = cyc + 2; s.v = shadow[video_rd_addr];
            vq.push_back(s);
        end
        if (issue) begin
            s.due = cyc + 2; s.v = shadow[rd_a];
            hq.push_back(s);
        end
        if (host_wr_valid && ready_e) begin
            w.a = host_wr_addr; w.d = host_wr_data;
            wq.push_back(w);
        end
        if (host_wr_valid && !ready_e) ovf_m = 1;
        else if (ovf_clear)            ovf_m = 0;
        if (!rd_active && host_rd_req) begin
            rd_active = 1; rd_t = cyc; rd_a = host_rd_addr;
            rd_drained = 0; rd_issued = 0;
        end else if (rd_active && rd_issued && cyc == rd_ic + 1) begin
            rd_active = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  t_req;
        int  lat;
        int  pulses;
        bit  seen;
        idle_inputs();
        rst_n = 0;
        load_en = 0; load_addr = '0; load_data = '0;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            load_en   = 1;
            load_addr = 8'(i);
            load_data = (i == 5) ? 12'hABC : 12'($urandom);
            shadow[i] = load_data;
            @(posedge clk); #1;
        end
        load_en = 0;
        @(negedge clk);
        chk("rst_wr_ready", host_wr_ready, 1);
        chk("rst_ram_wr_en", ram_wr_en, 0);
        chk("rst_ram_addr", ram_addr, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("rel_vid_data", video_rd_data, 0);
        chk("rel_rd_data", host_rd_data, 0);
        chk("rel_rd_valid", host_rd_valid, 0);
        chk("rel_rd_busy", host_rd_busy, 0);
        chk("rel_overflow", wr_overflow, 0);
        chk("rel_ram_addr", ram_addr, 0);
        chk("rel_wr_ready", host_wr_ready, 1);
        @(posedge clk); #1;

        // Video every other cycle at index 5 while three host writes are queued.
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            video_rd_req  = (i % 2 == 0);
            video_rd_addr = 8'h05;
            if (i < 3) begin
                host_wr_valid = 1;
                host_wr_addr  = 8'h10 + 8'(i);
                host_wr_data  = 12'h111 * 12'(i + 1);
            end
            step();
        end
        idle_inputs();
        step();
        chk("ram_10", mem[8'h10], 12'h111);
        chk("ram_11", mem[8'h11], 12'h222);
        chk("ram_12", mem[8'h12], 12'h333);

        // Continuous video starves drain: fill FIFO, overflow on the fifth write.
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            video_rd_req  = 1;
            video_rd_addr = 8'($urandom);
            host_wr_valid = 1;
            host_wr_addr  = 8'h30 + 8'(i);
            host_wr_data  = 12'($urandom);
            step();
        end
        chk("ovf_set", wr_overflow, 1);
        chk("full_ready", host_wr_ready, 0);
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            step();
        end
        chk("drained_ready", host_wr_ready, 1);
        idle_inputs();
        ovf_clear = 1;
        step();
        idle_inputs();
        step();
        chk("ovf_cleared", wr_overflow, 0);

        // Read-after-write ordering.
        idle_inputs();
        host_wr_valid = 1; host_wr_addr = 8'h20; host_wr_data = 12'hF0F;
        step();
        idle_inputs();
        host_rd_req = 1; host_rd_addr = 8'h20;
        step();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            idle_inputs();
            step();
            if (obs_valid) begin
                seen = 1;
                chk("raw_data", host_rd_data, 12'hF0F);
            end
        end
        chk("raw_valid_seen", seen, 1);

        // Minimum read latency; a second request while busy is ignored.
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            step();
        end
        idle_inputs();
        host_rd_req = 1; host_rd_addr = 8'h05;
        t_req = cyc;
        step();
        idle_inputs();
        host_rd_req = 1; host_rd_addr = 8'h10;
        step();
        lat = -1; pulses = 0;
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            step();
            if (obs_valid) begin
                pulses++;
                if (lat < 0) lat = cyc - 1 - t_req;
            end
        end
        chk("rd_latency", lat, 3);
        chk("rd_pulses", pulses, 1);

        // Write pushed during active video, then blanking.
        idle_inputs();
        video_blank = 0; host_wr_valid = 1;
        host_wr_addr = 8'h40; host_wr_data = 12'h5A5;
        step();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            video_blank = 0;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            step();
        end
        chk("ram_40", mem[8'h40], 12'h5A5);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            idle_inputs();
            video_rd_req  = ($urandom_range(0, 99) < 50);
            video_rd_addr = 8'($urandom);
            video_blank   = ($urandom_range(0, 99) < 40);
            host_wr_valid = ($urandom_range(0, 99) < 45);
            host_wr_addr  = 8'($urandom_range(0, 15));
            host_wr_data  = 12'($urandom);
            host_rd_req   = ($urandom_range(0, 99) < 12);
            host_rd_addr  = 8'($urandom_range(0, 15));
            ovf_clear     = ($urandom_range(0, 99) < 8);
            step();
        end
        for (int i = 0; i < 20; i++) begin
            idle_inputs();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/palette_access_ctrl.md
Name: palette_access_ctrl

Overview:
- Arbitrates the single-port 256x12 palette RAM between the video pixel pipeline and host register-bus accesses.
- Each video read slot is served unconditionally, with fixed latency, so the pixel pipeline never stalls.
- Host writes are buffered in a small FIFO and drained into unused RAM slots.
- Host reads are ordered behind all pending writes.

Parameters:
- FIFO_DEPTH, 4, host write FIFO entries (power of two, 2..16).
- ADDR_W, 8, palette index width.
- DATA_W, 12, palette entry width (4:4:4 RGB).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- video_rd_req  in  1  video pixel slot; RAM read of video_rd_addr this cycle.
- video_rd_addr  in  ADDR_W  pixel palette index.
- video_blank  in  1  1 outside active display area.
- video_rd_data  out  DATA_W  palette colour for the requested index.
- host_wr_valid  in  1  host write request.
- host_wr_ready  out  1  FIFO can accept a write.
- host_wr_addr  in  ADDR_W  host write index.
- host_wr_data  in  DATA_W  host write colour.
- host_rd_req  in  1  single-cycle host read pulse.
- host_rd_addr  in  ADDR_W  host read index.
- host_rd_busy  out  1  host read in progress.
- host_rd_valid  out  1  one-cycle pulse; host_rd_data valid.
- host_rd_data  out  DATA_W  host read result.
- wr_overflow  out  1  sticky: write presented while host_wr_ready=0.
- ovf_clear  in  1  clears wr_overflow.
- ram_addr  out  ADDR_W  RAM address.
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_data  out  DATA_W  RAM write data.
- ram_rd_data  in  DATA_W  RAM read data; valid one cycle after ram_addr.

Behaviour:
- Reset values (rst_n=0 at a clk edge):
  - video_rd_data=0, host_rd_data=0, host_rd_valid=0, host_rd_busy=0, wr_overflow=0, ram_wr_en=0, ram_addr=0.
  - FIFO is emptied.
  - host_wr_ready is combinational !full, so it reads 1 during and after reset.
- Slot priority per cycle, fixed: video read > host read issue > FIFO drain.
- Video read:
  - When video_rd_req=1, ram_addr=video_rd_addr and ram_wr_en=0 that cycle.
  - video_rd_data is registered from ram_rd_data, so it is valid exactly 2 cycles after the req.
  - video_rd_data holds its value until the next video read result lands.
- Write FIFO:
  - Push when host_wr_valid & host_wr_ready.
  - host_wr_ready=0 when count==FIFO_DEPTH. A pop in the same cycle does not make a full FIFO ready; ready follows the registered count.
  - Pop when the slot is free (no video req, no host read issue): ram_addr=head addr, ram_wr_en=1, ram_wr_data=head data.
  - Entries are written in push order.
  - Simultaneous push and pop leaves count unchanged.
- Overflow:
  - host_wr_valid & !host_wr_ready sets wr_overflow; the data is dropped.
  - ovf_clear clears it; a set in the same cycle as ovf_clear wins.
- Host read FSM:
  - IDLE: on host_rd_req, latch host_rd_addr, set busy, go to DRAIN. A host_rd_req while busy is ignored.
  - DRAIN: wait until FIFO count==0, so a read returns all previously accepted writes. Then go to ISSUE.
  - ISSUE: wait for a cycle with video_rd_req=0. In that cycle drive ram_addr=latched addr and go to CAPT.
  - CAPT: host_rd_data<=ram_rd_data, host_rd_valid=1 for one cycle, busy=0, back to IDLE.
  - Minimum latency from host_rd_req to host_rd_valid, with FIFO empty and no video traffic: 3 cycles.
- Host writes may still be pushed while a read is pending. Those later writes are not waited for once DRAIN has exited.
- Continuous video_rd_req starves FIFO drain and host reads. This is legal; the timing generator guarantees free cycles every other clock.

Optional Feature:
- PALETTE_BLANK_ONLY_WR_EN defined: FIFO drain is permitted only when video_blank=1.
  - Writes pushed during active video stay queued until blanking, which avoids mid-line colour tearing.
  - Host reads still wait in DRAIN for an empty FIFO.
- Undefined: drain in any slot not used by video or a host read.

Test Plan:
- Reset with rst_n=0 for 2 cycles, then release: all outputs 0, host_wr_ready=1, FIFO empty.
- video_rd_req every other cycle, addr 0x05, RAM[0x05]=0xABC; 3 host writes (0x10=0x111, 0x11=0x222, 0x12=0x333) -> writes occur only in non-req cycles, in order; video_rd_data=0xABC exactly 2 cycles after each req.
- 5 back-to-back host writes with video_rd_req held 1 (FIFO_DEPTH=4):
  - host_wr_ready drops after the 4th write.
  - The 5th write sets wr_overflow and is dropped.
  - After video_rd_req is released the FIFO drains 4 entries; ovf_clear then resets the flag.
- Host write 0x20=0xF0F, then host_rd_req addr 0x20 on the next cycle -> host_rd_valid pulses once with host_rd_data=0xF0F; busy is high until then.
- Host read with idle video and empty FIFO -> host_rd_valid exactly 3 cycles after host_rd_req. A second host_rd_req while busy -> ignored.
- With PALETTE_BLANK_ONLY_WR_EN: write pushed while video_blank=0 -> ram_wr_en stays 0 until video_blank=1, then the write occurs in the first free slot.
